dma_copy_engine: RTL

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_copy_engine.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy engine: FSM state encoding and
// default sizing parameters.
package dma_pkg;

    localparam int DMA_LEN_W  = 16;
    localparam int DMA_STRIDE = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_GNT  = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_GNT  = 3'd5,
        ST_FINISH  = 3'd6
    } dma_state_e;

endpackage

// File: rtl/dma_copy_engine.sv
// Single-word-at-a-time DMA copy engine: read src word, write it to dst, repeat.
// Optional macro DMA_FILL_EN adds a fill mode that writes a constant word.
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int LEN_W  = DMA_LEN_W,
    parameter int STRIDE = DMA_STRIDE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      src_addr,
    input  logic [63:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
`ifdef DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [63:0]      fill_data,
`endif
    output logic             busy,
    output logic             done,
    output logic             req_dma,
    output logic             we_dma,
    output logic [63:0]      addr_dma,
    output logic [63:0]      wdata_dma,
    input  logic             gnt_dma,
    input  logic             valid_dma,
    input  logic [63:0]      rdata_dma
);

    localparam logic [63:0] STEP = 64'(STRIDE);

    dma_state_e       state;
    logic [63:0]      cur_src;
    logic [63:0]      cur_dst;
    logic [LEN_W-1:0] remaining;
    logic [63:0]      buffer;
    logic             fill_q;
    logic [63:0]      fill_word_q;

`ifdef DMA_FILL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q      <= 1'b0;
            fill_word_q <= '0;
        end else if (state == ST_IDLE && start) begin
            fill_q      <= fill_mode;
            fill_word_q <= fill_data;
        end
    end
`else
    assign fill_q      = 1'b0;
    assign fill_word_q = '0;
`endif

    assign wdata_dma = buffer;

    // Request outputs are registered and coincide with the *_REQ state, so a
    // request is always followed by a GNT cycle with req low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_dma   <= 1'b0;
            we_dma    <= 1'b0;
            addr_dma  <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            buffer    <= '0;
        end else begin
            req_dma <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_src   <= src_addr;
                        cur_dst   <= dst_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            state <= ST_FINISH;
`ifdef DMA_FILL_EN
                        end else if (fill_mode) begin
                            state    <= ST_WR_REQ;
                            req_dma  <= 1'b1;
                            we_dma   <= 1'b1;
                            addr_dma <= dst_addr;
                            buffer   <= fill_data;
`endif
                        end else begin
                            state    <= ST_RD_REQ;
                            req_dma  <= 1'b1;
                            we_dma   <= 1'b0;
                            addr_dma <= src_addr;
                        end
                    end
                end
                ST_RD_REQ: state <= ST_RD_GNT;
                ST_RD_GNT: begin
                    if (gnt_dma) begin
                        state <= ST_RD_DATA;
                    end else begin
                        state   <= ST_RD_REQ;
                        req_dma <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (valid_dma) begin
                        buffer   <= rdata_dma;
                        state    <= ST_WR_REQ;
                        req_dma  <= 1'b1;
                        we_dma   <= 1'b1;
                        addr_dma <= cur_dst;
                    end
                end
                ST_WR_REQ: state <= ST_WR_GNT;
                ST_WR_GNT: begin
                    if (gnt_dma) begin
                        cur_src   <= cur_src + STEP;
                        cur_dst   <= cur_dst + STEP;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= ST_FINISH;
                        end else if (fill_q) begin
                            state    <= ST_WR_REQ;
                            req_dma  <= 1'b1;
                            we_dma   <= 1'b1;
                            addr_dma <= cur_dst + STEP;
                            buffer   <= fill_word_q;
                        end else begin
                            state    <= ST_RD_REQ;
                            req_dma  <= 1'b1;
                            we_dma   <= 1'b0;
                            addr_dma <= cur_src + STEP;
                        end
                    end else begin
                        state   <= ST_WR_REQ;
                        req_dma <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
